signal_meter: RTL
=================

// Module: signal_meter
// PURPOSE
//  Parametrised single-input measurement engine. It measures frequency, period or duty cycle
//  of Sig_in and publishes one result per measurement with a 1-cycle valid strobe.
//  It sits between the on-board signal generator outputs and the 8-digit display driver.
//  It replaces three separate fixed-width meters with one engine, selected at run time.
// PARAMETERS
//  CNT_W          32           internal counter width
//  OUT_W          16           Result width; larger values saturate
//  GATE_CYCLES    100_000_000  FREQ gate window in Clk cycles (1 s at 100 MHz)
//  PER_TICK       100          PERIOD unit in Clk cycles (100 -> 1 us at 100 MHz); >=1
//  TIMEOUT_CYCLES 50_000_000   max Clk cycles waiting for an edge; must be < 2**CNT_W
// PORTS
//  Clk         in   1      system clock
//  Rst_n       in   1      asynchronous active-low reset
//  En          in   1      1 = measure; 0 = abort to IDLE
//  Mode        in   2      00 FREQ, 01 PERIOD, 10 DUTY, 11 reserved (held in IDLE)
//  Sig_in      in   1      asynchronous signal under test
//  Result      out  OUT_W  last result: Hz-per-gate / PER_TICK units / per-mille
//  Result_vld  out  1      1-cycle strobe; Result updated the same cycle
//  Overflow    out  1      last result saturated to 2**OUT_W-1
//  Timeout     out  1      last PERIOD/DUTY attempt saw no edge within TIMEOUT_CYCLES
//  Busy        out  1      FSM is not in IDLE
// BEHAVIOUR
//  - Reset: Result=0, Result_vld=0, Overflow=0, Timeout=0, Busy=0, FSM=IDLE, all counters=0.
//  - Sig_in passes through a 2-flop synchroniser and then an edge detector (rise/fall pulses).
//    Edge pulses appear 3 cycles after the pin changes.
//  - FSM: IDLE -> (En & Mode!=11) ARM/GATE -> MEASURE -> [DIVIDE] -> DONE -> next measurement.
//  - FREQ: GATE counts exactly GATE_CYCLES cycles, starting the cycle after IDLE exits.
//    Rise pulses are counted during those cycles, including the last one.
//    DONE lasts 1 cycle: it latches the count, pulses Result_vld, then a new gate starts.
//    No edge is counted in the DONE cycle.
//  - PERIOD: ARM waits for a rise. MEASURE counts PER_TICK-cycle ticks until the next rise.
//    The prescaler restarts at each rise.
//    Result_vld is asserted the cycle after that rise. The terminating rise also opens the
//    next period, so periods are measured back-to-back.
//  - DUTY: ARM waits for a rise. MEASURE counts Clk cycles as period P and high time H
//    until the next rise. DIVIDE is a restoring divider, 1 quotient bit per cycle,
//    CNT_W+10 cycles: floor(H*1000/P).
//    DONE pulses Result_vld, then the FSM goes to ARM. A rise during DIVIDE is ignored.
//  - Saturation: if a FREQ or PERIOD value is >= 2**OUT_W-1, Result=2**OUT_W-1 and Overflow=1.
//    Counters stop at all-ones and never wrap. DUTY is always <= 1000 and never overflows.
//  - Timeout: applies in ARM or MEASURE, PERIOD/DUTY only. After TIMEOUT_CYCLES with no rise:
//    Result=0, Timeout=1, Result_vld pulse, FSM -> ARM.
//  - Overflow and Timeout are updated on every Result_vld and hold until the next one.
//  - En=0, or a Mode change while Busy: FSM -> IDLE the next cycle, counters cleared,
//    Result/Overflow/Timeout held, no Result_vld.
//  - Async reset mid-operation: everything returns to reset values immediately,
//    with no partial result.
//  - Edge exactly at the timeout boundary: the edge wins and a measurement is produced.
// TESTING  (GATE_CYCLES=1000, PER_TICK=1, TIMEOUT_CYCLES=5000, OUT_W=16, CNT_W=32 unless noted)
//  1 FREQ, Sig_in square wave with period 10 clk -> Result=100 every 1001 cycles;
//    Overflow=0, Timeout=0.
//  2 PERIOD, Sig_in period 40 clk -> first Result_vld one cycle after the 2nd rise,
//    Result=40; then a strobe every 40 cycles.
//  3 DUTY, Sig_in high 10 / low 30 -> Result=250; a 1/1 square wave -> Result=500.
//  4 PERIOD, Sig_in stuck low -> Result_vld at ARM+5000 cycles: Result=0, Timeout=1;
//    repeats every 5000 cycles.
//  5 PERIOD, TIMEOUT_CYCLES=200000, Sig_in period 70000 -> Result=65535, Overflow=1;
//    then period 100 -> Result=100, Overflow=0.
//  6 DUTY mid-MEASURE: pulse Rst_n low -> all outputs 0 at once.
//    Separately, toggle Mode mid-measure -> no Result_vld, Result held, Busy drops for
//    >= 1 cycle.

Source files
------------

// File: rtl/signal_meter.sv
// rtl/signal_meter.sv - run-time selectable frequency / period / duty-cycle meter
// One FSM and two shared counters serve all three modes; results saturate to OUT_W bits.
module signal_meter #(
    parameter int CNT_W          = 32,
    parameter int OUT_W          = 16,
    parameter int GATE_CYCLES    = 100_000_000,
    parameter int PER_TICK       = 100,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic             Sig_in,
    output logic [OUT_W-1:0] Result,
    output logic             Result_vld,
    output logic             Overflow,
    output logic             Timeout,
    output logic             Busy
);
    localparam int DW  = CNT_W + 10;
    localparam int DCW = $clog2(DW);
    localparam logic [1:0] M_FREQ = 2'b00;
    localparam logic [1:0] M_PER  = 2'b01;
    localparam logic [1:0] M_DUTY = 2'b10;
    localparam logic [1:0] M_RSVD = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(PER_TICK - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RES_MAX   = CNT_W'({OUT_W{1'b1}});
    localparam logic [DCW-1:0]   DIV_LAST  = DCW'(DW - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_GATE, S_MEAS, S_DIV, S_DONE} state_t;
    state_t state, state_nxt;

    logic             s1, s2, s3, rise, level;
    logic [1:0]       mode_q;
    // evt_cnt: FREQ edges / PERIOD ticks / DUTY high time
    // cyc_cnt: FREQ gate / PERIOD prescaler / DUTY period
    logic [CNT_W-1:0] evt_cnt, cyc_cnt, to_cnt, evt_inc, cyc_inc;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic [CNT_W:0]   rem_sh;
    logic             rem_ge;
    logic [DW-1:0]    dvd, dvd_nxt;
    logic [DCW-1:0]   div_cnt;
    logic             abort, timeout_hit, tick_now, emit, emit_to, emit_ovf;
    logic [CNT_W-1:0] emit_raw;
    logic [OUT_W-1:0] emit_res;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= Sig_in;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end
    // s3 is the level aligned with the registered rise pulse
    assign level = s3;

    assign evt_inc  = (evt_cnt == CNT_MAX) ? evt_cnt : evt_cnt + 1'b1;
    assign cyc_inc  = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + 1'b1;
    assign rem_sh   = {rem, dvd[DW-1]};
    assign rem_ge   = rem_sh >= {1'b0, cyc_cnt};
    assign rem_nxt  = rem_ge ? CNT_W'(rem_sh - {1'b0, cyc_cnt}) : rem_sh[CNT_W-1:0];
    assign dvd_nxt  = {dvd[DW-2:0], rem_ge};
    assign emit_ovf = emit_raw >= RES_MAX;
    assign emit_res = emit_ovf ? '1 : emit_raw[OUT_W-1:0];
    assign Busy     = (state != S_IDLE);

    always_comb begin
        state_nxt   = state;
        emit        = 1'b0;
        emit_to     = 1'b0;
        emit_raw    = '0;
        abort       = (state != S_IDLE) && (!En || Mode != mode_q);
        tick_now    = (cyc_cnt == TICK_LAST);
        timeout_hit = (state == S_ARM || state == S_MEAS) && !rise && (to_cnt == TO_LAST);
        case (state)
            S_IDLE: if (En && Mode != M_RSVD) state_nxt = (Mode == M_FREQ) ? S_GATE : S_ARM;
            S_ARM: begin
                if (rise) begin
                    state_nxt = S_MEAS;
                end else if (timeout_hit) begin
                    emit    = 1'b1;
                    emit_to = 1'b1;
                end
            end
            S_GATE: begin
                if (cyc_cnt == GATE_LAST) begin
                    state_nxt = S_DONE;
                    emit      = 1'b1;
                    emit_raw  = rise ? evt_inc : evt_cnt;
                end
            end
            S_MEAS: begin
                if (rise) begin
                    if (mode_q == M_PER) begin
                        state_nxt = S_DONE;
                        emit      = 1'b1;
                        emit_raw  = tick_now ? evt_inc : evt_cnt;
                    end else begin
                        state_nxt = S_DIV;
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_ARM;
                    emit      = 1'b1;
                    emit_to   = 1'b1;
                end
            end
            S_DIV: begin
                if (div_cnt == DIV_LAST) begin
                    state_nxt = S_DONE;
                    emit      = 1'b1;
                    emit_raw  = dvd_nxt[CNT_W-1:0];
                end
            end
            S_DONE: state_nxt = (mode_q == M_FREQ) ? S_GATE : (mode_q == M_PER) ? S_MEAS : S_ARM;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            emit      = 1'b0;
            emit_to   = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            mode_q     <= 2'b00;
            Result     <= '0;
            Result_vld <= 1'b0;
            Overflow   <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            Result_vld <= emit;
            if (state == S_IDLE) mode_q <= Mode;
            if (emit) begin
                Result   <= emit_res;
                Overflow <= emit_ovf;
                Timeout  <= emit_to;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            evt_cnt <= '0;
            cyc_cnt <= '0;
            to_cnt  <= '0;
            rem     <= '0;
            dvd     <= '0;
            div_cnt <= '0;
        end else begin
            // the edge-wait timer restarts on every rise and whenever ARM is (re)entered
            if (state == S_IDLE || state_nxt == S_IDLE || state == S_DIV || rise || emit_to ||
                mode_q == M_FREQ || (state == S_DONE && mode_q == M_DUTY))
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (state_nxt == S_IDLE) begin
                evt_cnt <= '0;
                cyc_cnt <= '0;
            end else begin
                case (state)
                    S_GATE: begin
                        cyc_cnt <= cyc_inc;
                        if (rise) evt_cnt <= evt_inc;
                    end
                    S_ARM: begin
                        evt_cnt <= (rise && mode_q == M_DUTY) ? CNT_W'(1) : '0;
                        cyc_cnt <= (rise && mode_q == M_DUTY) ? CNT_W'(1) : '0;
                    end
                    S_MEAS, S_DONE: begin
                        if (mode_q == M_PER) begin
                            if (rise) begin
                                evt_cnt <= '0;
                                cyc_cnt <= '0;
                            end else if (tick_now) begin
                                cyc_cnt <= '0;
                                evt_cnt <= evt_inc;
                            end else begin
                                cyc_cnt <= cyc_inc;
                            end
                        end else if (mode_q == M_DUTY) begin
                            if (state == S_MEAS && !rise) begin
                                cyc_cnt <= cyc_inc;
                                if (level) evt_cnt <= evt_inc;
                            end
                        end else begin
                            evt_cnt <= '0;
                            cyc_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end

            if (state == S_MEAS && rise && mode_q == M_DUTY) begin
                dvd     <= DW'(evt_cnt) * DW'(1000);
                rem     <= '0;
                div_cnt <= '0;
            end else if (state == S_DIV) begin
                dvd     <= dvd_nxt;
                rem     <= rem_nxt;
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule
